// File: rtl/bit_count_engine_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bit_count_engine_if
// Brief    : Start/done handshake, operand and display bundle for the
//            bit counting engine.
// Revision : 1.0 - initial release
// ============================================================================
interface bit_count_engine_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] result;
  logic [6:0]       hex0;
  logic [6:0]       hex1;

  // Requester side: drives the run request and operand, observes status.
  modport master (
    output start, mode, data_in,
    input  busy, done, result, hex0, hex1
  );

  // Engine side.
  modport slave (
    input  start, mode, data_in,
    output busy, done, result, hex0, hex1
  );
endinterface
`default_nettype wire

// File: rtl/bit_count_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bit_count_engine
// Brief    : Counts the ones (or zeros) of a loaded word by shifting right one
//            bit per clock; shows the count in binary and on two active-low
//            decimal 7-segment digits. Ones mode stops early once the
//            remaining word is zero.
// Revision : 1.0 - initial release
// ============================================================================
module bit_count_engine #(
  parameter int WIDTH = 8
) (
  input  wire logic           clock,
  input  wire logic           reset,
  bit_count_engine_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           ps_q, ps_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             m_q, m_d;
  logic [CNT_W-1:0] bits_left_q, bits_left_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             finished;
  logic [6:0]       res_ext;
  logic [6:0]       units;
  logic [6:0]       tens;

  // Active-low {g..a} encoding of one decimal digit.
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // Next-state and datapath: load while idle, one bit per clock while shifting.
  always_comb begin
    ps_d        = ps_q;
    a_d         = a_q;
    m_d         = m_q;
    bits_left_d = bits_left_q;
    result_d    = result_q;
    // Ones mode can stop once nothing set remains; the bit budget bounds both.
    finished    = (bits_left_q == '0) || (!m_q && (a_q == '0));
    case (ps_q)
      S_IDLE: begin
        if (!bus.start) begin
          a_d         = bus.data_in;
          m_d         = bus.mode;
          bits_left_d = C_WIDTH;
        end else begin
          ps_d     = S_SHIFT;
          result_d = '0;
        end
      end
      S_SHIFT: begin
        if (finished) begin
          ps_d = S_DONE;
        end else begin
          result_d    = result_q + CNT_W'(a_q[0] == ~m_q);
          a_d         = a_q >> 1;
          bits_left_d = bits_left_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!bus.start) ps_d = S_IDLE;
      end
      default: ps_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ps_q        <= S_IDLE;
      a_q         <= '0;
      m_q         <= 1'b0;
      bits_left_q <= C_WIDTH;
      result_q    <= '0;
    end else begin
      ps_q        <= ps_d;
      a_q         <= a_d;
      m_q         <= m_d;
      bits_left_q <= bits_left_d;
      result_q    <= result_d;
    end
  end

  // Status decodes registered state only; display is combinational from result.
  always_comb begin
    res_ext   = 7'(result_q);
    units     = res_ext % 7'd10;
    tens      = res_ext / 7'd10;
    bus.busy   = (ps_q == S_SHIFT);
    bus.done   = (ps_q == S_DONE);
    bus.result = result_q;
    bus.hex0   = seg(units[3:0]);
    bus.hex1   = seg(tens[3:0]);
  end
endmodule
`default_nettype wire

// File: doc/bit_count_engine.md
# bit_count_engine

Parametrised bit-counting engine with integrated control and datapath. It loads a WIDTH-bit word, counts either its 1s or its 0s by shifting right one bit per clock, and presents the count as a binary result and as two active-low decimal 7-segment digits. In ones mode it terminates early once the remaining word is zero. It uses a level start/done handshake so it can be driven directly by a board switch and LED, or by a host FSM.

## Interface
Parameters:
- WIDTH, 8, input word width; legal range 1..99.
- CNT_W, derived localparam = $clog2(WIDTH+1), width of the result.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request; 0 = idle/load, 1 = run.
- mode  in  1  0 = count ones, 1 = count zeros; sampled only in S_IDLE.
- data_in  in  WIDTH  word to count; sampled only in S_IDLE.
- busy  out  1  high while in S_SHIFT.
- done  out  1  high while in S_DONE.
- result  out  CNT_W  binary count.
- hex0  out  7  active-low segments {g..a}, units digit of result.
- hex1  out  7  active-low segments {g..a}, tens digit of result.

## Operation
- States: S_IDLE, S_SHIFT, S_DONE. Registers: shift register A[WIDTH-1:0], latched mode m, bits_left (counts WIDTH down to 0), result.
- S_IDLE:
  - If start=0, on each edge: A <= data_in, m <= mode, bits_left <= WIDTH. result holds its previous value.
  - If start=1, on the edge: go to S_SHIFT, result <= 0. A and m are not reloaded; they keep the values from the last start=0 cycle.
- S_SHIFT:
  - finished = (bits_left==0) || (m==0 && A==0).
  - If not finished, on the edge:
    - result <= result + (A[0] == ~m);
    - A <= A >> 1, with zero fill;
    - bits_left <= bits_left - 1.
  - If finished, go to S_DONE with no update.
  - start, mode and data_in are ignored in this state; no abort.
- S_DONE:
  - result is frozen.
  - start=0 causes a transition to S_IDLE on the next edge.
  - start=1 holds S_DONE.
- Width rules:
  - result never exceeds WIDTH, so CNT_W bits never overflow.
  - Zero fill in ones mode can never add counts.
  - In zeros mode, zero-filled bits are never processed because bits_left bounds the loop.
- Display:
  - hex0 = seg(result % 10), hex1 = seg(result / 10). Both are combinational from result.
  - seg encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Reset, from any state including mid-S_SHIFT, on the edge:
  - ps <= S_IDLE;
  - A <= 0, m <= 0, bits_left <= WIDTH, result <= 0.
  - After reset: busy=0, done=0, hex0=hex1=1000000.

## Timing
- busy and done decode registered state only, with no combinational path from start.
- Let k be the number of bits processed:
  - ones mode: k = index of the highest set bit + 1, or 0 if the word is zero;
  - zeros mode: k = WIDTH.
- If start is sampled 1 in S_IDLE at edge E0:
  - busy is high from E0 until edge E0+k+1;
  - done rises at E0+k+1.
- result is final from E0+k onward.
- done falls one edge after start is sampled 0 in S_DONE.
- A new run needs at least one S_IDLE cycle with start=0 to load data.
- start held high continuously after done causes no restart.

## Test plan
- WIDTH=8, mode=0, data_in=8'b00101101, start 0→1 at E0 -> busy for 7 cycles; done at E0+7; result=4; hex0=0011001; hex1=1000000.
- WIDTH=8, mode=1, same data -> busy for 9 cycles; done at E0+9; result=4. Changing data_in and mode during S_SHIFT leaves the result unchanged.
- WIDTH=8, mode=0, data_in=0 -> busy for exactly 1 cycle; done at E0+1; result=0; hex0=1000000.
- WIDTH=8, mode=0, data_in=8'hFF -> result=8. With start held high, done stays high for 5 cycles. start→0 makes done=0 one edge later, with the state back in S_IDLE.
- Reset asserted 3 cycles into S_SHIFT -> next edge: busy=0, done=0, result=0, hex0=hex1=1000000. A following start run counts correctly.
- WIDTH=16 instance, mode=0, data_in=16'hFFFF -> done at E0+17; result=16; hex1=1111001; hex0=0000010.
